// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
// Shared types and helpers for the HDMI PLL lock sequencer.
//   pll_state_e : sequencer state encoding
//   cnt_width() : width of the shared cycle counter, i.e. clog2 of the
//                 largest of the three cycle-count parameters (min 1 bit)
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } pll_state_e;

    // The counter only ever has to reach (parameter - 1), so clog2 of the
    // largest parameter is enough; a degenerate all-ones setup still needs
    // one bit so the counter vector stays legal.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Generic two-flop single-bit synchronizer for bringing an asynchronous
// level into the clk domain.
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input bit
//   q   : synchronized output, two clk cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_d;
    logic meta_q;
    logic sync_d;
    logic sync_q;

    // The first stage may go metastable; only the second stage is consumed.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Both stages clear on reset so the consumer sees a known "not locked".
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Brings the HDMI PLL from power-up to a usable state and supervises it.
// Runs on the PLL reference clock. Pulses the PLL reset, waits for a
// qualified lock, holds the video domains in reset until lock has been
// stable long enough, retries on timeout and latches a fault once the
// retry budget is spent.
// Ports:
//   clk         : PLL reference clock
//   rst         : synchronous active-high reset
//   pll_lock    : raw PLL lock flag (asynchronous)
//   restart     : one-cycle request to rerun the whole sequence
//   pll_reset   : PLL reset, high only while pulsing the PLL
//   video_rst   : reset request to the video domains, low only in RUN
//   ready       : lock is stable and video is released
//   fault       : retry budget exhausted, sticky until rst/restart
//   retry_count : timed-out attempts since the last rst/restart
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RESET_PULSE_CYCLES  = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       video_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count
);

    localparam int CW = cnt_width(RESET_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                  LOCK_TIMEOUT_CYCLES);

    localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

    logic          lock_s;

    pll_state_e    state_d,     state_q;
    logic [CW-1:0] cnt_d,       cnt_q;
    logic [3:0]    retry_d,     retry_q;
    logic          pll_reset_d, pll_reset_q;
    logic          video_rst_d, video_rst_q;
    logic          ready_d,     ready_q;
    logic          fault_d,     fault_q;
    logic [3:0]    retry_inc;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // Next-state logic. restart overrides every other transition. The shared
    // counter restarts from zero on any state entry (including re-entering
    // PLL_RST via restart) and is frozen in RUN/FAULT where nothing is timed.
    // Outputs are decoded from the next state so each one changes on the
    // same edge that enters the state driving it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        retry_inc = (retry_q < RETRY_MAX) ? retry_q + 4'd1 : retry_q;
        retry_d   = retry_q;

        if (restart) begin
            state_d = PLL_RST;
            retry_d = '0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == RESET_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_MAX) ? FAULT : PLL_RST;
                    end
                end
                STABLE: begin
                    // A dropout sends us back to waiting without counting
                    // a retry; the timeout starts over from zero.
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    cnt_d = cnt_q;
                    if (!lock_s) state_d = PLL_RST;
                end
                FAULT: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = PLL_RST;
                end
            endcase
        end

        if (restart || (state_d != state_q)) cnt_d = '0;

        pll_reset_d = (state_d == PLL_RST);
        video_rst_d = (state_d != RUN);
        ready_d     = (state_d == RUN);
        fault_d     = (state_d == FAULT);
    end

    // Single state register for the FSM, shared counter and registered
    // outputs; reset lands in PLL_RST with the PLL held in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            video_rst_q <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            video_rst_q <= video_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_reset   = pll_reset_q;
    assign video_rst   = video_rst_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
// Directed bench for pll_lock_sequencer with short parameters
// (pulse 4, stable 8, timeout 32, retries 2). Expected values are
// hand-derived cycle offsets from the edge on which each stimulus is applied.
module tb_pll_lock_sequencer;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       restart;
    logic       pll_reset;
    logic       video_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;

    int total_checks = 0;
    int bad_checks   = 0;

    pll_lock_sequencer #(
        .RESET_PULSE_CYCLES  (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .restart     (restart),
        .pll_reset   (pll_reset),
        .video_rst   (video_rst),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count)
    );

    // Free-running reference clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs, then advance the given number of rising edges and settle
    // 1 unit past the last one so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic rst_v, input logic lock_v,
                                 input logic restart_v, input int cycles);
        rst      = rst_v;
        pll_lock = lock_v;
        restart  = restart_v;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // The one comparison point of the bench.
    task automatic checkOutput(input string tag, input logic [3:0] actual,
                               input logic [3:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
        end
    endtask

    // Compare every output against an expected set.
    task automatic checkAll(input string tag, input logic exp_pll_reset,
                            input logic exp_video_rst, input logic exp_ready,
                            input logic exp_fault, input logic [3:0] exp_retry);
        checkOutput({tag, ".pll_reset"},   {3'b0, pll_reset}, {3'b0, exp_pll_reset});
        checkOutput({tag, ".video_rst"},   {3'b0, video_rst}, {3'b0, exp_video_rst});
        checkOutput({tag, ".ready"},       {3'b0, ready},     {3'b0, exp_ready});
        checkOutput({tag, ".fault"},       {3'b0, fault},     {3'b0, exp_fault});
        checkOutput({tag, ".retry_count"}, retry_count,       exp_retry);
    endtask

    initial begin
        logic       exp_pr;
        logic [3:0] exp_rc;

        // Power-up reset.
        $display("[TB] power-up reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 2);
        checkAll("reset", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        // Normal lock: 4-cycle PLL reset, lock 10 cycles after release,
        // ready exactly 11 cycles after the lock edge.
        $display("[TB] normal lock");
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1);
            checkAll($sformatf("norm.k%0d", k), (k < 4), 1'b1, 1'b0, 1'b0, 4'd0);
        end
        for (int j = 1; j <= 11; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1);
            checkAll($sformatf("norm.j%0d", j), 1'b0, (j < 11), (j == 11), 1'b0, 4'd0);
        end

        // Loss of lock in RUN: video back in reset 3 cycles later, then a
        // 4-cycle PLL pulse and a normal relock.
        $display("[TB] loss of lock in run");
        for (int j = 1; j <= 7; j++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1);
            checkAll($sformatf("loss.j%0d", j), (j >= 3 && j < 7), (j >= 3),
                     (j < 3), 1'b0, 4'd0);
        end
        for (int j = 1; j <= 11; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1);
            checkAll($sformatf("relock.j%0d", j), 1'b0, (j < 11), (j == 11), 1'b0, 4'd0);
        end

        // Lock glitch during STABLE: drop lock to reach WAIT_LOCK, then
        // high 5, low 1, high; ready 11 cycles after the second rise.
        $display("[TB] lock glitch during stable");
        applyStimulus(1'b0, 1'b0, 1'b0, 8);
        checkAll("glitch.wait", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        for (int j = 1; j <= 11; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1);
            checkAll($sformatf("glitch.j%0d", j), 1'b0, (j < 11), (j == 11), 1'b0, 4'd0);
        end

        // Timeouts to FAULT: restart out of RUN with lock held low. Two
        // pulse+timeout rounds (36 cycles each) end in FAULT.
        $display("[TB] timeouts to fault");
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkAll("tmo.k0", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 1; k <= 80; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1);
            exp_pr = (k < 4) || (k >= 36 && k < 40);
            exp_rc = (k >= 72) ? 4'd2 : ((k >= 36) ? 4'd1 : 4'd0);
            checkAll($sformatf("tmo.k%0d", k), exp_pr, 1'b1, 1'b0, (k >= 72), exp_rc);
        end

        // Restart from FAULT: cleared on the next cycle, fresh pulse, then
        // one timeout so retry_count is nonzero before the mid-STABLE reset.
        $display("[TB] restart from fault");
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkAll("rst_fault.k0", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1);
            exp_pr = (k < 4) || (k >= 36 && k < 40);
            exp_rc = (k >= 36) ? 4'd1 : 4'd0;
            checkAll($sformatf("rst_fault.k%0d", k), exp_pr, 1'b1, 1'b0, 1'b0, exp_rc);
        end

        // Reset mid-STABLE: lock rises, 6 cycles later we are in STABLE;
        // a one-cycle rst returns every output to its reset value.
        $display("[TB] reset mid-stable");
        applyStimulus(1'b0, 1'b1, 1'b0, 6);
        checkAll("mid.stable", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1);
        checkAll("mid.reset", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        // Sync flops restart from 0: ready 13 cycles after release.
        for (int k = 1; k <= 13; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1);
            checkAll($sformatf("post.k%0d", k), (k < 4), (k < 13), (k == 13), 1'b0, 4'd0);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
